// File: rtl/mvau_pkg.sv
// rtl/mvau_pkg.sv - shared MVAU constants and datapath typedefs
package mvau_pkg;

   localparam int SIMD     = 4;
   localparam int TDstI    = 16;
   localparam int TDst     = 32;
   localparam int SF       = 8;
   localparam int SIMD_LOG = $clog2(SIMD);

   typedef logic signed [TDstI-1:0] prod_t;
   typedef logic signed [TDst-1:0]  acc_t;

endpackage

// File: rtl/mvu_pe_acc_if.sv
// rtl/mvu_pe_acc_if.sv - product beat input and PE result output bundle
interface mvu_pe_acc_if #(
   parameter int SIMD  = mvau_pkg::SIMD,
   parameter int TDstI = mvau_pkg::TDstI,
   parameter int TDst  = mvau_pkg::TDst
);

   logic                    in_v;
   logic [SIMD*TDstI-1:0]   in_prod;
   logic                    out_v;
   logic [TDst-1:0]         out;

   modport master (output in_v, output in_prod, input out_v, input out);
   modport slave  (input in_v, input in_prod, output out_v, output out);

endinterface

// File: rtl/mvu_pe_adder_tree.sv
// rtl/mvu_pe_adder_tree.sv - sign-extending pairwise adder tree; MVU_PE_ADDER_PIPE_EN registers each level
module mvu_pe_adder_tree #(
   parameter int SIMD  = mvau_pkg::SIMD,
   parameter int TDstI = mvau_pkg::TDstI,
   parameter int TDst  = mvau_pkg::TDst
) (
`ifdef MVU_PE_ADDER_PIPE_EN
   input  logic                  clk,
   input  logic                  rst_n,
`endif
   input  logic                  in_v_i,
   input  logic [SIMD*TDstI-1:0] in_prod_i,
   output logic                  tree_v_o,
   output logic [TDst-1:0]       tree_sum_o
);

   localparam int LOG = $clog2(SIMD);

   typedef logic signed [TDst-1:0] word_t;

   // Level 0 holds the sign-extended lanes; level k holds SIMD>>k partial sums.
   for (genvar k = 0; k <= LOG; k++) begin : g_lvl
      localparam int N = SIMD >> k;
      word_t d [N];
      logic  v;

      if (k == 0) begin : g_leaf
         for (genvar i = 0; i < SIMD; i++) begin : g_lane
            assign d[i] = {{(TDst-TDstI){in_prod_i[i*TDstI+TDstI-1]}},
                           in_prod_i[i*TDstI +: TDstI]};
         end
         assign v = in_v_i;
      end else begin : g_node
         word_t s [N];
         for (genvar j = 0; j < N; j++) begin : g_add
            assign s[j] = g_lvl[k-1].d[2*j] + g_lvl[k-1].d[2*j+1];
         end
`ifdef MVU_PE_ADDER_PIPE_EN
         word_t d_q [N];
         logic  v_q;

         // Level register: data and its valid advance together every cycle, no stall.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               v_q <= 1'b0;
               for (int j = 0; j < N; j++) d_q[j] <= '0;
            end else begin
               v_q <= g_lvl[k-1].v;
               d_q <= s;
            end
         end
         assign d = d_q;
         assign v = v_q;
`else
         assign d = s;
         assign v = g_lvl[k-1].v;
`endif
      end
   end

   assign tree_sum_o = g_lvl[LOG].d[0];
   assign tree_v_o   = g_lvl[LOG].v;

endmodule

// File: rtl/mvu_pe_acc.sv
// rtl/mvu_pe_acc.sv - PE reduction: adder tree plus SF-beat fold accumulator (MVU_PE_ADDER_PIPE_EN adds tree latency)
module mvu_pe_acc #(
   parameter int SIMD  = mvau_pkg::SIMD,
   parameter int TDstI = mvau_pkg::TDstI,
   parameter int TDst  = mvau_pkg::TDst,
   parameter int SF    = mvau_pkg::SF
) (
   input  logic        clk,
   input  logic        rst_n,
   mvu_pe_acc_if.slave bus
);

   localparam int CW = (SF > 1) ? $clog2(SF) : 1;

   typedef logic signed [TDst-1:0] word_t;

   logic          tree_v;
   logic [TDst-1:0] tree_sum;

   logic [CW-1:0] sf_cnt_q, sf_cnt_d;
   word_t         acc_q, acc_d;
   word_t         out_q, out_d;
   logic          out_v_q, out_v_d;
   word_t         fold_sum;

   mvu_pe_adder_tree #(
      .SIMD  (SIMD),
      .TDstI (TDstI),
      .TDst  (TDst)
   ) u_tree (
`ifdef MVU_PE_ADDER_PIPE_EN
      .clk        (clk),
      .rst_n      (rst_n),
`endif
      .in_v_i     (bus.in_v),
      .in_prod_i  (bus.in_prod),
      .tree_v_o   (tree_v),
      .tree_sum_o (tree_sum)
   );

   // Fold step: the first beat loads acc (no clear cycle), the last beat emits the result.
   always_comb begin
      sf_cnt_d = sf_cnt_q;
      acc_d    = acc_q;
      out_d    = out_q;
      out_v_d  = 1'b0;
      fold_sum = (sf_cnt_q == '0) ? word_t'(tree_sum) : acc_q + word_t'(tree_sum);
      if (tree_v) begin
         if (sf_cnt_q == CW'(SF-1)) begin
            out_d    = fold_sum;
            out_v_d  = 1'b1;
            sf_cnt_d = '0;
         end else begin
            acc_d    = fold_sum;
            sf_cnt_d = sf_cnt_q + CW'(1);
         end
      end
   end

   // Fold state and result registers; reset discards any partial fold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sf_cnt_q <= '0;
         acc_q    <= '0;
         out_q    <= '0;
         out_v_q  <= 1'b0;
      end else begin
         sf_cnt_q <= sf_cnt_d;
         acc_q    <= acc_d;
         out_q    <= out_d;
         out_v_q  <= out_v_d;
      end
   end

   assign bus.out   = out_q;
   assign bus.out_v = out_v_q;

endmodule

// File: tb/tb_mvu_pe_acc.sv
// tb/tb_mvu_pe_acc.sv - scoreboard bench for mvu_pe_acc over several SF/width instances
module tb_mvu_pe_acc;
   import mvau_pkg::*;

`ifdef MVU_PE_ADDER_PIPE_EN
   localparam int LAT = 1 + SIMD_LOG;
`else
   localparam int LAT = 1;
`endif

   localparam int NI = 6;
   localparam int SF_TAB [NI] = '{1, 2, 3, 4, 8, 2};
   localparam int W_TAB  [NI] = '{16, 16, 16, 16, 16, 30};

   typedef struct {
      logic [31:0] val;
      int          due;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_v = 1'b0;
   logic [31:0] lane [SIMD];

   exp_t        exp_q [NI][$];
   longint      acc_m [NI];
   int          cnt_m [NI];
   logic [31:0] last_val [NI];
   int          npulse [NI];
   int          n_vec = 0;
   int          n_err = 0;
   int          cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int W   = W_TAB[g];
      localparam int SFV = SF_TAB[g];

      mvu_pe_acc_if #(.SIMD(SIMD), .TDstI(W), .TDst(TDst)) bus ();

      assign bus.in_v = in_v;
      for (genvar j = 0; j < SIMD; j++) begin : g_ln
         assign bus.in_prod[j*W +: W] = lane[j][W-1:0];
      end

      mvu_pe_acc #(.SIMD(SIMD), .TDstI(W), .TDst(TDst), .SF(SFV)) dut (
         .clk   (clk),
         .rst_n (rst_n),
         .bus   (bus)
      );

      exp_t e;
      always @(negedge clk) begin
         #1;
         if (!rst_n) begin
            n_vec++;
            if (bus.out_v !== 1'b0 || bus.out !== 32'd0) begin
               n_err++;
               $display("FAIL reset_clear[%0d]: out_v=%b out=%h, required 0/00000000", g, bus.out_v, bus.out);
            end
            last_val[g] = 32'd0;
         end else if (bus.out_v === 1'b1) begin
            n_vec++;
            if (exp_q[g].size() == 0) begin
               n_err++;
               $display("FAIL spurious_pulse[%0d]: out=%h at cycle %0d, no result due", g, bus.out, cyc);
            end else begin
               e = exp_q[g].pop_front();
               if (bus.out !== e.val || cyc != e.due) begin
                  n_err++;
                  $display("FAIL result[%0d]: out=%h cycle %0d, required %h cycle %0d", g, bus.out, cyc, e.val, e.due);
               end
            end
            last_val[g] = bus.out;
            npulse[g]++;
         end else begin
            n_vec++;
            if (bus.out !== last_val[g]) begin
               n_err++;
               $display("FAIL hold[%0d]: out=%h, required %h", g, bus.out, last_val[g]);
            end
            if (exp_q[g].size() != 0 && exp_q[g][0].due <= cyc) begin
               n_vec++;
               n_err++;
               e = exp_q[g].pop_front();
               $display("FAIL missing_pulse[%0d]: no out_v at cycle %0d, required %h", g, e.due, e.val);
            end
         end
      end
   end

   function automatic longint sext(input logic [31:0] v, input int w);
      longint r;
      r = longint'(v & ((32'd1 << w) - 32'd1));
      if (v[w-1]) r = r - (longint'(1) << w);
      return r;
   endfunction

   // Present one beat and let every instance's reference fold it as plain arithmetic.
   task automatic beat(input int a, input int b, input int c, input int d);
      longint s;
      lane[0] = a; lane[1] = b; lane[2] = c; lane[3] = d;
      in_v = 1'b1;
      for (int i = 0; i < NI; i++) begin
         s = 0;
         for (int j = 0; j < SIMD; j++) s += sext(lane[j], W_TAB[i]);
         acc_m[i] += s;
         cnt_m[i]++;
         if (cnt_m[i] == SF_TAB[i]) begin
            exp_q[i].push_back('{val: acc_m[i][31:0], due: cyc + LAT});
            acc_m[i] = 0;
            cnt_m[i] = 0;
         end
      end
      @(negedge clk);
      in_v = 1'b0;
   endtask

   task automatic idle(input int n);
      in_v = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic reset_pulse();
      idle(LAT + 2);
      rst_n = 1'b0;
      for (int i = 0; i < NI; i++) begin
         exp_q[i].delete();
         acc_m[i] = 0;
         cnt_m[i] = 0;
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   initial begin
      int p0, p1;
      for (int j = 0; j < SIMD; j++) lane[j] = 32'd0;
      for (int i = 0; i < NI; i++) begin
         acc_m[i] = 0; cnt_m[i] = 0; last_val[i] = 32'd0; npulse[i] = 0;
      end
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      idle(2);

      // SF=2, lanes 1..4 twice
      reset_pulse();
      p0 = npulse[1];
      beat(1, 2, 3, 4); beat(1, 2, 3, 4);
      idle(LAT + 3);
      check_eq("sf2_sum", last_val[1], 32'd20);
      check_eq("sf2_pulses", 32'(npulse[1] - p0), 32'd1);

      // SF=1, negative lanes
      reset_pulse();
      p0 = npulse[0];
      beat(-5, 3, -1, 0); beat(-5, 3, -1, 0);
      idle(LAT + 3);
      check_eq("sf1_neg", last_val[0], 32'hFFFF_FFFD);
      check_eq("sf1_pulses", 32'(npulse[0] - p0), 32'd2);

      // SF=4 with idle gaps between beats
      reset_pulse();
      p0 = npulse[3];
      beat(1, 2, 3, 4); idle(1);
      beat(1, 2, 3, 4); beat(1, 2, 3, 4); idle(3);
      beat(1, 2, 3, 4); idle(LAT + 6);
      check_eq("sf4_gapped", last_val[3], 32'd40);
      check_eq("sf4_gapped_pulses", 32'(npulse[3] - p0), 32'd1);

      // 30-bit lanes, SF=2, modulo 2^32 wrap
      reset_pulse();
      beat(32'h1FFF_FFFF, 32'h1FFF_FFFF, 32'h1FFF_FFFF, 32'h1FFF_FFFF);
      beat(32'h1FFF_FFFF, 32'h1FFF_FFFF, 32'h1FFF_FFFF, 32'h1FFF_FFFF);
      idle(LAT + 3);
      check_eq("wrap", last_val[5], 32'hFFFF_FFF8);

      // SF=4 partial fold discarded by reset
      reset_pulse();
      beat(7, 0, 0, 0); beat(7, 0, 0, 0);
      reset_pulse();
      p0 = npulse[3];
      for (int k = 0; k < 4; k++) beat(1, 0, 0, 0);
      idle(LAT + 3);
      check_eq("midfold_reset", last_val[3], 32'd4);
      check_eq("midfold_pulses", 32'(npulse[3] - p0), 32'd1);

      // SF=3, six back-to-back beats
      reset_pulse();
      p0 = npulse[2];
      p1 = npulse[0];
      for (int k = 1; k <= 6; k++) beat(k, 0, 0, 0);
      idle(LAT + 3);
      check_eq("b2b_sum", last_val[2], 32'd15);
      check_eq("b2b_pulses", 32'(npulse[2] - p0), 32'd2);
      check_eq("sf1_b2b_pulses", 32'(npulse[0] - p1), 32'd6);

      // Random beats, gaps and occasional mid-stream resets
      reset_pulse();
      for (int n = 0; n < 500; n++) begin
         if ($urandom_range(0, 99) == 0) reset_pulse();
         if ($urandom_range(0, 3) != 0)
            beat(int'($urandom()), int'($urandom()), int'($urandom()), int'($urandom()));
         else
            idle($urandom_range(1, 3));
      end
      idle(LAT + 4);
      for (int i = 0; i < NI; i++) check_eq("drained", 32'(exp_q[i].size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
